// File: rtl/pipeline_fetch_q.sv
// Fetch stage: sequential/redirected PC generation, one imem read per cycle, and a
// DEPTH-entry queue of {pc, mode, instr} drained by decode through valid/ready.
module pipeline_fetch_q #(
   parameter int unsigned       PC_W       = 32,
   parameter int unsigned       INSTR_W    = 32,
   parameter int unsigned       MODE_W     = 1,
   parameter logic [PC_W-1:0]   RESET_PC   = {PC_W{1'b0}},
   parameter logic [MODE_W-1:0] RESET_MODE = {MODE_W{1'b0}},
   parameter int unsigned       PC_STEP    = 4,
   parameter int unsigned       DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     f_stall,
   input  logic                     redir_valid,
   input  logic [PC_W-1:0]          redir_pc,
   input  logic [MODE_W-1:0]        redir_mode,
   output logic                     imem_req,
   output logic [PC_W-1:0]          imem_addr,
   input  logic [INSTR_W-1:0]       imem_rdata,
   output logic                     d_valid,
   input  logic                     d_ready,
   output logic [PC_W-1:0]          d_pc,
   output logic [MODE_W-1:0]        d_mode,
   output logic [INSTR_W-1:0]       d_instr,
   output logic [PC_W-1:0]          f_pc,
   output logic [MODE_W-1:0]        f_mode,
   output logic [$clog2(DEPTH):0]   q_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [PC_W-1:0]  STEP     = PC_W'(PC_STEP);

   logic [PC_W-1:0]    f_pc_q, f_pc_d;
   logic [MODE_W-1:0]  f_mode_q, f_mode_d;
   logic               inflight_q, inflight_d;
   logic [PC_W-1:0]    tag_pc_q, tag_pc_d;
   logic [MODE_W-1:0]  tag_mode_q, tag_mode_d;
   logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
   logic [MODE_W-1:0]  hold_mode_q, hold_mode_d;
   logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;

   logic [PC_W-1:0]    mem_pc_q    [DEPTH];
   logic [MODE_W-1:0]  mem_mode_q  [DEPTH];
   logic [INSTR_W-1:0] mem_instr_q [DEPTH];

   logic [CNT_W-1:0]   occ_s;
   logic               issue_s, enq_s, deq_s, valid_s;

   // Credit counts the outstanding read so a full queue never receives a response.
   always_comb begin
      occ_s   = count_q + {{(CNT_W-1){1'b0}}, inflight_q};
      valid_s = (count_q != {CNT_W{1'b0}});
      issue_s = !f_stall && !redir_valid && (occ_s < CNT_FULL);
      enq_s   = inflight_q && !redir_valid;
      deq_s   = valid_s && d_ready && !redir_valid;
   end

   // Next-state for fetch PC, in-flight tag, queue pointers and held head.
   always_comb begin
      f_pc_d       = f_pc_q;
      f_mode_d     = f_mode_q;
      inflight_d   = issue_s;
      tag_pc_d     = tag_pc_q;
      tag_mode_d   = tag_mode_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      hold_pc_d    = hold_pc_q;
      hold_mode_d  = hold_mode_q;
      hold_instr_d = hold_instr_q;

      if (redir_valid) begin
         f_pc_d   = redir_pc;
         f_mode_d = redir_mode;
      end else if (issue_s) begin
         f_pc_d     = f_pc_q + STEP;
         tag_pc_d   = f_pc_q;
         tag_mode_d = f_mode_q;
      end else begin
         f_pc_d = f_pc_q;
      end

      if (redir_valid) begin
         head_d  = tail_q;
         count_d = {CNT_W{1'b0}};
      end else begin
         if (deq_s) begin
            head_d = head_q + PTR_ONE;
         end else begin
            head_d = head_q;
         end
         if (enq_s) begin
            tail_d = tail_q + PTR_ONE;
         end else begin
            tail_d = tail_q;
         end
         case ({enq_s, deq_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end

      // Remember the visible head so outputs stay stable once the queue empties.
      if (valid_s) begin
         hold_pc_d    = mem_pc_q[head_q];
         hold_mode_d  = mem_mode_q[head_q];
         hold_instr_d = mem_instr_q[head_q];
      end else begin
         hold_pc_d    = hold_pc_q;
         hold_mode_d  = hold_mode_q;
         hold_instr_d = hold_instr_q;
      end
   end

   // Control and status registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         f_pc_q       <= RESET_PC;
         f_mode_q     <= RESET_MODE;
         inflight_q   <= 1'b0;
         tag_pc_q     <= {PC_W{1'b0}};
         tag_mode_q   <= {MODE_W{1'b0}};
         head_q       <= {PTR_W{1'b0}};
         tail_q       <= {PTR_W{1'b0}};
         count_q      <= {CNT_W{1'b0}};
         hold_pc_q    <= {PC_W{1'b0}};
         hold_mode_q  <= {MODE_W{1'b0}};
         hold_instr_q <= {INSTR_W{1'b0}};
      end else begin
         f_pc_q       <= f_pc_d;
         f_mode_q     <= f_mode_d;
         inflight_q   <= inflight_d;
         tag_pc_q     <= tag_pc_d;
         tag_mode_q   <= tag_mode_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         hold_pc_q    <= hold_pc_d;
         hold_mode_q  <= hold_mode_d;
         hold_instr_q <= hold_instr_d;
      end
   end

   // Queue storage; written only by an unflushed response.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_pc_q[i]    <= {PC_W{1'b0}};
            mem_mode_q[i]  <= {MODE_W{1'b0}};
            mem_instr_q[i] <= {INSTR_W{1'b0}};
         end
      end else if (enq_s) begin
         mem_pc_q[tail_q]    <= tag_pc_q;
         mem_mode_q[tail_q]  <= tag_mode_q;
         mem_instr_q[tail_q] <= imem_rdata;
      end else begin
         mem_pc_q[tail_q] <= mem_pc_q[tail_q];
      end
   end

   assign imem_req  = issue_s;
   assign imem_addr = f_pc_q;
   assign f_pc      = f_pc_q;
   assign f_mode    = f_mode_q;
   assign q_count   = count_q;
   assign d_valid   = valid_s;
   assign d_pc      = valid_s ? mem_pc_q[head_q]    : hold_pc_q;
   assign d_mode    = valid_s ? mem_mode_q[head_q]  : hold_mode_q;
   assign d_instr   = valid_s ? mem_instr_q[head_q] : hold_instr_q;

endmodule

// File: tb/tb_pipeline_fetch_q.sv
// Directed vector bench for pipeline_fetch_q with a one-cycle-latency imem model
// whose data is a fixed function of the address.
module tb_pipeline_fetch_q;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        f_stall, redir_valid, d_ready;
   logic [31:0] redir_pc;
   logic [0:0]  redir_mode;
   logic        imem_req;
   logic [31:0] imem_addr, imem_rdata;
   logic        d_valid;
   logic [31:0] d_pc, d_instr, f_pc;
   logic [0:0]  d_mode, f_mode;
   logic [2:0]  q_count;

   int n_checks = 0;
   int n_errors = 0;

   pipeline_fetch_q #(
      .PC_W(32), .INSTR_W(32), .MODE_W(1), .RESET_PC(32'h0), .RESET_MODE(1'b0),
      .PC_STEP(4), .DEPTH(4)
   ) dut (
      .clk(clk), .resetn(resetn), .f_stall(f_stall), .redir_valid(redir_valid),
      .redir_pc(redir_pc), .redir_mode(redir_mode), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .d_valid(d_valid),
      .d_ready(d_ready), .d_pc(d_pc), .d_mode(d_mode), .d_instr(d_instr),
      .f_pc(f_pc), .f_mode(f_mode), .q_count(q_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= imem_req ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;

   typedef struct {
      logic        rst, stall, redir;
      logic [31:0] rpc;
      logic        rmode, ready;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_fmode, e_dv;
      logic [31:0] e_dpc;
      logic        e_dmode;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void v(input logic rst, stall, redir, input logic [31:0] rpc,
                             input logic rmode, ready, e_req, input logic [31:0] e_addr,
                             input logic e_fmode, e_dv, input logic [31:0] e_dpc,
                             input logic e_dmode, input logic [2:0] e_cnt);
      vec_t t;
      t.rst = rst; t.stall = stall; t.redir = redir; t.rpc = rpc; t.rmode = rmode;
      t.ready = ready; t.e_req = e_req; t.e_addr = e_addr; t.e_fmode = e_fmode;
      t.e_dv = e_dv; t.e_dpc = e_dpc; t.e_dmode = e_dmode; t.e_cnt = e_cnt;
      vecs.push_back(t);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      // rst stall redir rpc rmode ready | req addr fmode dv dpc dmode cnt
      // streaming, fill to full, one-slot drain, redirect flush
      v(1,0,0,32'h0,0,1, 1,32'h00,0, 0,32'h0,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h04,0, 0,32'h0,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h08,0, 1,32'h0,0,3'd1);
      v(0,0,0,32'h0,0,1, 1,32'h0C,0, 1,32'h4,0,3'd1);
      v(0,0,0,32'h0,0,0, 1,32'h10,0, 1,32'h8,0,3'd1);
      v(0,0,0,32'h0,0,0, 1,32'h14,0, 1,32'h8,0,3'd2);
      v(0,0,0,32'h0,0,0, 0,32'h18,0, 1,32'h8,0,3'd3);
      v(0,0,0,32'h0,0,0, 0,32'h18,0, 1,32'h8,0,3'd4);
      v(0,0,0,32'h0,0,1, 0,32'h18,0, 1,32'h8,0,3'd4);
      v(0,0,0,32'h0,0,0, 1,32'h18,0, 1,32'hC,0,3'd3);
      v(0,0,0,32'h0,0,0, 0,32'h1C,0, 1,32'hC,0,3'd3);
      v(0,0,0,32'h0,0,0, 0,32'h1C,0, 1,32'hC,0,3'd4);
      v(0,0,1,32'h100,1,1, 0,32'h1C,0, 1,32'hC,0,3'd4);
      v(0,0,0,32'h0,0,1, 1,32'h100,1, 0,32'hC,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h104,1, 0,32'hC,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h108,1, 1,32'h100,1,3'd1);
      v(0,0,0,32'h0,0,1, 1,32'h10C,1, 1,32'h104,1,3'd1);
      // redirect in the cycle after issuing 0x8 drops that response
      v(1,0,0,32'h0,0,1, 1,32'h00,0, 0,32'h0,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h04,0, 0,32'h0,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h08,0, 1,32'h0,0,3'd1);
      v(0,0,1,32'h100,1,1, 0,32'h0C,0, 1,32'h4,0,3'd1);
      v(0,0,0,32'h0,0,1, 1,32'h100,1, 0,32'h4,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h104,1, 0,32'h4,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h108,1, 1,32'h100,1,3'd1);
      // three stall cycles: in-flight word delivered, queue drains, resume at frozen PC
      v(1,0,0,32'h0,0,1, 1,32'h00,0, 0,32'h0,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h04,0, 0,32'h0,0,3'd0);
      v(0,1,0,32'h0,0,1, 0,32'h08,0, 1,32'h0,0,3'd1);
      v(0,1,0,32'h0,0,1, 0,32'h08,0, 1,32'h4,0,3'd1);
      v(0,1,0,32'h0,0,1, 0,32'h08,0, 0,32'h4,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h08,0, 0,32'h4,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h0C,0, 0,32'h4,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h10,0, 1,32'h8,0,3'd1);
      // stall together with redirect
      v(1,1,1,32'h200,1,1, 0,32'h00,0, 0,32'h0,0,3'd0);
      v(0,1,0,32'h0,0,1, 0,32'h200,1, 0,32'h0,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h200,1, 0,32'h0,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h204,1, 0,32'h0,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h208,1, 1,32'h200,1,3'd1);
      // PC wrap at the top of the address space
      v(1,0,1,32'hFFFF_FFFC,0,1, 0,32'h00,0, 0,32'h0,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'hFFFF_FFFC,0, 0,32'h0,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h00,0, 0,32'h0,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h04,0, 1,32'hFFFF_FFFC,0,3'd1);
      v(0,0,0,32'h0,0,1, 1,32'h08,0, 1,32'h0,0,3'd1);
      // back-to-back redirects: the last one wins
      v(1,0,1,32'h300,1,1, 0,32'h00,0, 0,32'h0,0,3'd0);
      v(0,0,1,32'h400,0,1, 0,32'h300,1, 0,32'h0,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h400,0, 0,32'h0,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h404,0, 0,32'h0,0,3'd0);
      v(0,0,0,32'h0,0,1, 1,32'h408,0, 1,32'h400,0,3'd1);

      resetn = 1'b0; f_stall = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0;
      redir_mode = 1'b0; d_ready = 1'b0;
      #1;
      chk("reset.q_count", {29'd0, q_count}, 32'd0);
      chk("reset.d_valid", {31'd0, d_valid}, 32'd0);
      chk("reset.f_pc", f_pc, 32'h0);
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) begin
            resetn = 1'b0;
            #1;
            resetn = 1'b1;
         end
         f_stall = vecs[i].stall; redir_valid = vecs[i].redir; redir_pc = vecs[i].rpc;
         redir_mode = vecs[i].rmode; d_ready = vecs[i].ready;
         #1;
         chk($sformatf("v%0d.imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
         chk($sformatf("v%0d.imem_addr", i), imem_addr, vecs[i].e_addr);
         chk($sformatf("v%0d.f_pc", i), f_pc, vecs[i].e_addr);
         chk($sformatf("v%0d.f_mode", i), {31'd0, f_mode}, {31'd0, vecs[i].e_fmode});
         chk($sformatf("v%0d.d_valid", i), {31'd0, d_valid}, {31'd0, vecs[i].e_dv});
         chk($sformatf("v%0d.d_pc", i), d_pc, vecs[i].e_dpc);
         chk($sformatf("v%0d.d_mode", i), {31'd0, d_mode}, {31'd0, vecs[i].e_dmode});
         chk($sformatf("v%0d.q_count", i), {29'd0, q_count}, {29'd0, vecs[i].e_cnt});
         if (vecs[i].e_dv)
            chk($sformatf("v%0d.d_instr", i), d_instr, vecs[i].e_dpc ^ KEY);
         @(posedge clk);
         #1;
      end

      // asynchronous reset in the middle of a cycle while the queue holds entries
      resetn = 1'b0; #1; resetn = 1'b1;
      f_stall = 1'b0; redir_valid = 1'b0; d_ready = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("midrst.pre_count", {29'd0, q_count}, 32'd2);
      chk("midrst.pre_f_pc", f_pc, 32'hC);
      #2;
      resetn = 1'b0;
      #1;
      chk("midrst.q_count", {29'd0, q_count}, 32'd0);
      chk("midrst.d_valid", {31'd0, d_valid}, 32'd0);
      chk("midrst.f_pc", f_pc, 32'h0);
      resetn = 1'b1;
      #1;
      chk("midrst.resume_req", {31'd0, imem_req}, 32'd1);
      chk("midrst.resume_addr", imem_addr, 32'h0);
      @(posedge clk);
      #1;
      chk("midrst.next_addr", imem_addr, 32'h4);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
